// File: rtl/axi_lite_cfg_if.sv
// AXI4-Lite bus bundle between the panel_config master and the config slave.
// Every channel transfers on a rising clock edge where valid and ready are both high; valid
// never waits for ready, and payload must stay stable while valid is high and ready is low.
interface axi_lite_cfg_if;
  logic [6:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic [6:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cfg_slave.sv
// AXI4-Lite config slave: 32x32 register bank with ID/CTRL/STAT/CLR and a show-ahead
// command FIFO drained by the DSI command path.
module axi_lite_cfg_slave #(
  parameter logic [31:0] ID_VALUE  = 32'h4453_4931,
  parameter int          CMD_DEPTH = 16,
  parameter int          CMD_AW    = 4
) (
  input  logic               i_sys_clk,
  input  logic               i_arstn,
  axi_lite_cfg_if.slave      bus,
  output logic [31:0]        ctrl,
  output logic [31:0]        cmd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [2:0]         wr_state_dbg
);

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_EXEC = 3'd3,
    WR_RESP = 3'd4
  } wr_state_t;

  localparam logic [4:0] A_ID   = 5'd0;
  localparam logic [4:0] A_CTRL = 5'd1;
  localparam logic [4:0] A_STAT = 5'd2;
  localparam logic [4:0] A_CLR  = 5'd3;
  localparam logic [4:0] A_CMD  = 5'd4;

  wr_state_t   wr_state, wr_next;
  logic        live;
  logic        aw_fire, w_fire, ar_fire, exec, push, pop, full, empty, ovf;
  logic [4:0]  aw_word;
  logic [31:0] wdata_q, rd_mux, stat, rdata_q;
  logic [1:0]  bresp_q;
  logic [7:0]  wr_cnt;
  logic        rvalid_q;
  logic [31:0] regs [32];
  logic [31:0] mem [CMD_DEPTH];
  logic [CMD_AW:0] wptr, rptr, level;
  wire         unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0]};

  // Keeps every ready low while reset is held and for the first cycle after release.
  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) live <= 1'b0;
    else          live <= 1'b1;

  assign bus.awready = live && (wr_state == WR_IDLE || wr_state == WR_DATA);
  assign bus.wready  = live && (wr_state == WR_IDLE || wr_state == WR_ADDR);
  assign aw_fire     = bus.awvalid && bus.awready;
  assign w_fire      = bus.wvalid && bus.wready;

  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;

  always_comb begin
    wr_next     = wr_state;
    exec        = 1'b0;
    bus.bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_fire && w_fire) wr_next = WR_EXEC;
        else if (aw_fire)      wr_next = WR_ADDR;
        else if (w_fire)       wr_next = WR_DATA;
      end
      WR_ADDR: if (w_fire)  wr_next = WR_EXEC;
      WR_DATA: if (aw_fire) wr_next = WR_EXEC;
      WR_EXEC: begin
        exec    = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign wr_state_dbg = wr_state;
  assign bus.bresp    = bresp_q;

  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) begin
      aw_word <= '0;
      wdata_q <= '0;
    end else begin
      if (aw_fire) aw_word <= bus.awaddr[6:2];
      if (w_fire)  wdata_q <= bus.wdata;
    end

  // Register bank, write counter and response code all update in the execute cycle.
  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      wr_cnt  <= '0;
      bresp_q <= 2'b00;
      ovf     <= 1'b0;
    end else if (exec) begin
      wr_cnt  <= wr_cnt + 8'd1;
      bresp_q <= 2'b00;
      case (aw_word)
        A_ID, A_STAT: ;
        A_CLR: if (wdata_q[0]) ovf <= 1'b0;
        A_CMD: if (full) begin
          ovf     <= 1'b1;
          bresp_q <= 2'b10;
        end
        default: regs[aw_word] <= wdata_q;
      endcase
    end

  assign ctrl = regs[A_CTRL];

  // Command FIFO; full is taken from the registered pointers so a same-cycle pop cannot make room.
  assign level     = wptr - rptr;
  assign full      = level[CMD_AW];
  assign empty     = (wptr == rptr);
  assign push      = exec && (aw_word == A_CMD) && !full;
  assign cmd_valid = !empty;
  assign pop       = cmd_valid && cmd_ready;
  assign cmd_data  = empty ? 32'd0 : mem[rptr[CMD_AW-1:0]];

  always_ff @(posedge i_sys_clk)
    if (push) mem[wptr[CMD_AW-1:0]] <= wdata_q;

  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end

  assign stat = {16'd0, wr_cnt, 2'b00, ovf, full, 4'(level)};

  always_comb begin
    rd_mux = regs[bus.araddr[6:2]];
    case (bus.araddr[6:2])
      A_ID:         rd_mux = ID_VALUE;
      A_STAT:       rd_mux = stat;
      A_CLR, A_CMD: rd_mux = 32'd0;
      default:      ;
    endcase
  end

  assign bus.arready = live && !rvalid_q;
  assign ar_fire     = bus.arvalid && bus.arready;

  always_ff @(posedge i_sys_clk or negedge i_arstn)
    if (!i_arstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && bus.rready) begin
      rvalid_q <= 1'b0;
    end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = 2'b00;

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// Directed bench for axi_lite_cfg_slave: drivers push expected B/R/CMD results into queues
// and a negedge monitor pops and compares them whenever a handshake is presented.
module tb_axi_lite_cfg_slave;

  logic        sys_clk = 1'b0;
  logic        arstn   = 1'b0;
  logic [31:0] ctrl, cmd_data;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  wr_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_r_q[$];
  logic [31:0] exp_cmd_q[$];

  always #5 sys_clk = ~sys_clk;

  axi_lite_cfg_if bus ();

  axi_lite_cfg_slave dut (
    .i_sys_clk    (sys_clk),
    .i_arstn      (arstn),
    .bus          (bus),
    .ctrl         (ctrl),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .wr_state_dbg (wr_state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout", name);
  endtask

  // Scoreboard monitor: handshakes seen at negedge complete at the following posedge.
  always @(negedge sys_clk) begin
    if (arstn) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b_q.size() == 0) timeout("b_unexpected");
        else chk("bresp", 32'(bus.bresp), 32'(exp_b_q.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r_q.size() == 0) timeout("r_unexpected");
        else begin
          chk("rdata", bus.rdata, exp_r_q.pop_front());
          chk("rresp", 32'(bus.rresp), 32'd0);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) timeout("cmd_unexpected");
        else chk("cmd_data", cmd_data, exp_cmd_q.pop_front());
      end
    end
  end

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [1:0] er,
                           input bit pop_at_exec);
    bit aw_done, w_done;
    int n;
    exp_b_q.push_back(er);
    @(posedge sys_clk); #1;
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge sys_clk);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready)   w_done  = 1;
      @(posedge sys_clk); #1;
      if (aw_done) bus.awvalid = 1'b0;
      if (w_done)  bus.wvalid  = 1'b0;
      n++;
    end
    if (n >= 50) begin
      timeout("aw_w_accept");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    if (pop_at_exec) begin
      cmd_ready = 1'b1;
      @(posedge sys_clk); #1;
      cmd_ready = 1'b0;
    end
    n = 0;
    while (n < 50) begin
      @(negedge sys_clk);
      if (bus.bvalid && bus.bready) break;
      n++;
    end
    if (n >= 50) timeout("b_wait");
    @(posedge sys_clk); #1;
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [31:0] exp, input int hold);
    int n;
    exp_r_q.push_back(exp);
    bus.rready = (hold == 0);
    @(posedge sys_clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge sys_clk);
      if (bus.arready) break;
      n++;
    end
    if (n >= 50) timeout("ar_accept");
    @(posedge sys_clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
      chk("r_hold_data", bus.rdata, exp);
      @(posedge sys_clk); #1;
    end
    bus.rready = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge sys_clk);
      if (bus.rvalid && bus.rready) break;
      n++;
    end
    if (n >= 50) timeout("r_wait");
    @(posedge sys_clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(bus.awready), 32'd0);
    chk({tag, "_wready"},  32'(bus.wready),  32'd0);
    chk({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
    chk({tag, "_bresp"},   32'(bus.bresp),   32'd0);
    chk({tag, "_arready"}, 32'(bus.arready), 32'd0);
    chk({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    chk({tag, "_rdata"},   bus.rdata,        32'd0);
    chk({tag, "_ctrl"},    ctrl,             32'd0);
    chk({tag, "_cmd_data"}, cmd_data,        32'd0);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    cmd_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    arstn = 1'b1;

    // 1: ID read with rready held off for 3 cycles
    axi_read(7'h00, 32'h4453_4931, 3);

    // 2: AW in cycle 0, W in cycle 3, response in cycle 5
    @(posedge sys_clk); #1;
    bus.awaddr = 7'h04; bus.awvalid = 1'b1;
    @(negedge sys_clk); chk("t2_awready_c0", 32'(bus.awready), 32'd1);
    @(posedge sys_clk); #1; bus.awvalid = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    exp_b_q.push_back(2'b00);
    bus.wdata = 32'hA5A5_0001; bus.wvalid = 1'b1;
    @(negedge sys_clk); chk("t2_wready_c3", 32'(bus.wready), 32'd1);
    @(posedge sys_clk); #1; bus.wvalid = 1'b0;
    @(negedge sys_clk); chk("t2_bvalid_c4", 32'(bus.bvalid), 32'd0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk); chk("t2_bvalid_c5", 32'(bus.bvalid), 32'd1);
    @(posedge sys_clk); #1;
    chk("t2_ctrl", ctrl, 32'hA5A5_0001);
    axi_read(7'h08, 32'h0000_0100, 0);

    // Scratch write, RO write ignored, WO/RO reads
    axi_write(7'h7C, 32'hDEAD_BEEF, 2'b00, 0);
    axi_write(7'h00, 32'h1234_5678, 2'b00, 0);
    axi_read(7'h7C, 32'hDEAD_BEEF, 0);
    axi_read(7'h00, 32'h4453_4931, 0);
    axi_read(7'h10, 32'h0000_0000, 0);
    axi_read(7'h04, 32'hA5A5_0001, 0);

    // 3: fill the FIFO, then overflow
    for (int i = 0; i < 16; i++) begin
      exp_cmd_q.push_back(32'h100 + 32'(i));
      axi_write(7'h10, 32'h100 + 32'(i), 2'b00, 0);
    end
    axi_read(7'h08, 32'h0000_1310, 0);
    axi_write(7'h10, 32'hBAD0_0017, 2'b10, 0);
    axi_read(7'h08, 32'h0000_1430, 0);
    chk("t3_head", cmd_data, 32'h100);
    chk("t3_valid", 32'(cmd_valid), 32'd1);

    // 4: push into full FIFO while the consumer pops in the same cycle
    axi_write(7'h10, 32'hBAD0_0018, 2'b10, 1);
    axi_read(7'h08, 32'h0000_152F, 0);
    chk("t4_head", cmd_data, 32'h101);
    cmd_ready = 1'b1;
    for (int n = 0; n < 40 && cmd_valid; n++) @(posedge sys_clk);
    #1;
    cmd_ready = 1'b0;
    chk("t4_drained", 32'(cmd_valid), 32'd0);
    chk("t4_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    axi_write(7'h0C, 32'h0000_0001, 2'b00, 0);
    axi_read(7'h08, 32'h0000_1600, 0);

    // 5: response held off, then reset mid-hold
    axi_write(7'h10, 32'hC0DE_0001, 2'b00, 0);
    axi_write(7'h10, 32'hC0DE_0002, 2'b00, 0);
    chk("t5_fifo_loaded", 32'(cmd_valid), 32'd1);
    bus.bready = 1'b0;
    @(posedge sys_clk); #1;
    bus.awaddr = 7'h14; bus.wdata = 32'h5555_AAAA; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge sys_clk);
    chk("t5_aw_accept", 32'(bus.awready && bus.wready), 32'd1);
    @(posedge sys_clk); #1;
    bus.awaddr = 7'h7C; bus.wdata = 32'h0BAD_F00D;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("t5_hold_bvalid",  32'(bus.bvalid),  32'd1);
      chk("t5_hold_awready", 32'(bus.awready), 32'd0);
      chk("t5_hold_wready",  32'(bus.wready),  32'd0);
      @(posedge sys_clk); #1;
    end
    #2;
    arstn = 1'b0;
    #1;
    check_all_zero("t5_reset");
    exp_cmd_q.delete();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    arstn = 1'b1;
    chk("t5_fifo_empty", 32'(cmd_valid), 32'd0);
    axi_read(7'h08, 32'h0000_0000, 0);
    axi_read(7'h7C, 32'h0000_0000, 0);

    repeat (3) @(posedge sys_clk);
    #1;
    chk("end_b_q_empty", 32'(exp_b_q.size()), 32'd0);
    chk("end_r_q_empty", 32'(exp_r_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
